coin_validator: RTL and testbench



---
 rtl/coin_validator.sv | 254 +++++++++++++++++++++++++
 tb/tb_coin_validator.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_validator.sv
// coin_validator: conditions the 10-cent and 5-cent chute sensors into clean,
// one-cycle coin codes for the vending state machine.
//
// Ports:
//   clk                in   system clock
//   reset              in   synchronous, active-high reset
//   sense_10, sense_5  in   raw asynchronous chute sensors (high while a coin passes)
//   coins[1:0]         out  registered code: 00 none, 01 ten cents, 10 five cents
//   jam                out  registered, high while either channel is jammed
//   tally_10, tally_5  out  8-bit saturating accepted-coin counts
//                           (only when COIN_VALIDATOR_TALLY_EN is defined)
//
// Optional feature macro: COIN_VALIDATOR_TALLY_EN adds the tally counters and ports.
// Latency: a sensor first seen by the synchroniser at edge t yields its code on
// `coins` after edge t+DEBOUNCE_CYCLES+2.

// ---------------------------------------------------------------------------
// coin_validator_channel: synchroniser plus debounce/jam FSM for one chute.
// `accept` is a combinational one-cycle strobe in the cycle the coin qualifies;
// `jammed` stays set from JAM entry until the channel is back in IDLE.
// ---------------------------------------------------------------------------
module coin_validator_channel #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int JAM_CYCLES      = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic sense,
  output logic accept,
  output logic jammed
);

  localparam int JW = $clog2(JAM_CYCLES + 1);
  localparam logic [7:0]    DEBOUNCE_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [JW-1:0] JAM_LIMIT     = JW'(JAM_CYCLES);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARMING    = 3'd1,
    HELD      = 3'd2,
    RELEASING = 3'd3,
    JAM       = 3'd4
  } state_t;

  state_t        state, state_next;
  logic          sync_1, sync_2;
  logic [7:0]    count, count_next;
  logic [JW-1:0] jam_count, jam_count_next;
  logic          jammed_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_1    <= 1'b0;
      sync_2    <= 1'b0;
      state     <= IDLE;
      count     <= '0;
      jam_count <= '0;
      jammed    <= 1'b0;
    end else begin
      sync_1    <= sense;
      sync_2    <= sync_1;
      state     <= state_next;
      count     <= count_next;
      jam_count <= jam_count_next;
      jammed    <= jammed_next;
    end
  end

  always_comb begin
    state_next     = state;
    count_next     = count;
    jam_count_next = jam_count;
    jammed_next    = jammed;
    accept         = 1'b0;

    case (state)
      IDLE: begin
        if (sync_2) begin
          state_next = ARMING;
          count_next = 8'd1;
        end
      end

      ARMING: begin
        if (sync_2) begin
          // The sample that brings the run to DEBOUNCE_CYCLES is the acceptance.
          if (count == DEBOUNCE_LAST) begin
            accept         = 1'b1;
            state_next     = HELD;
            count_next     = '0;
            jam_count_next = '0;
          end else begin
            count_next = count + 8'd1;
          end
        end else begin
          state_next = IDLE;
          count_next = '0;
        end
      end

      HELD: begin
        if (sync_2) begin
          // Once the counter has reached JAM_CYCLES, the next high sample
          // commits the jam; the counter itself never exceeds the limit.
          if (jam_count == JAM_LIMIT) begin
            state_next  = JAM;
            jammed_next = 1'b1;
          end else begin
            jam_count_next = jam_count + JW'(1);
          end
        end else begin
          state_next = RELEASING;
          count_next = 8'd1;
        end
      end

      RELEASING: begin
        if (sync_2) begin
          state_next     = HELD;
          count_next     = '0;
          jam_count_next = '0;
        end else if (count == DEBOUNCE_LAST) begin
          state_next     = IDLE;
          count_next     = '0;
          jam_count_next = '0;
          jammed_next    = 1'b0;
        end else begin
          count_next = count + 8'd1;
        end
      end

      JAM: begin
        if (!sync_2) begin
          state_next = RELEASING;
          count_next = 8'd1;
        end
      end

      default: begin
        state_next     = IDLE;
        count_next     = '0;
        jam_count_next = '0;
        jammed_next    = 1'b0;
      end
    endcase
  end

endmodule

// ---------------------------------------------------------------------------
// coin_validator: two channels feeding a pending-flag arbiter with a gap timer.
// ---------------------------------------------------------------------------
module coin_validator #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int GAP_CYCLES      = 2,
  parameter int JAM_CYCLES      = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sense_10,
  input  logic       sense_5,
  output logic [1:0] coins,
  output logic       jam
`ifdef COIN_VALIDATOR_TALLY_EN
  ,
  output logic [7:0] tally_10,
  output logic [7:0] tally_5
`endif
);

  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  logic          accept_10, accept_5;
  logic          jammed_10, jammed_5;
  logic          pending_10, pending_5;
  logic          grant_10, grant_5;
  logic [GW-1:0] gap_count;

  coin_validator_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .JAM_CYCLES     (JAM_CYCLES)
  ) u_chan_10 (
    .clk   (clk),
    .reset (reset),
    .sense (sense_10),
    .accept(accept_10),
    .jammed(jammed_10)
  );

  coin_validator_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .JAM_CYCLES     (JAM_CYCLES)
  ) u_chan_5 (
    .clk   (clk),
    .reset (reset),
    .sense (sense_5),
    .accept(accept_5),
    .jammed(jammed_5)
  );

  // Fixed priority: ten cents wins a tie, five cents waits out the gap.
  always_comb begin
    grant_10 = 1'b0;
    grant_5  = 1'b0;
    if (gap_count == '0) begin
      if (pending_10) begin
        grant_10 = 1'b1;
      end else if (pending_5) begin
        grant_5 = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_10 <= 1'b0;
      pending_5  <= 1'b0;
      gap_count  <= '0;
      coins      <= 2'b00;
      jam        <= 1'b0;
    end else begin
      // Debounce outlasts the gap, so a flag is always clear before its
      // channel can accept again; set-after-clear ordering is only a safeguard.
      pending_10 <= (pending_10 & ~grant_10) | accept_10;
      pending_5  <= (pending_5 & ~grant_5) | accept_5;

      if (gap_count != '0) begin
        gap_count <= gap_count - GW'(1);
      end else if (grant_10 || grant_5) begin
        gap_count <= GW'(GAP_CYCLES);
      end

      coins <= grant_10 ? 2'b01 : (grant_5 ? 2'b10 : 2'b00);
      jam   <= jammed_10 | jammed_5;
    end
  end

`ifdef COIN_VALIDATOR_TALLY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      tally_10 <= 8'd0;
      tally_5  <= 8'd0;
    end else begin
      if (grant_10 && (tally_10 != 8'hFF)) begin
        tally_10 <= tally_10 + 8'd1;
      end
      if (grant_5 && (tally_5 != 8'hFF)) begin
        tally_5 <= tally_5 + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_coin_validator.sv
// Bench for coin_validator: directed scenarios plus randomised sensor traffic,
// every cycle compared against a debounced-level reference model.
module tb_coin_validator;

  localparam int D = 4;
  localparam int G = 2;
  localparam int J = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic       sense_10;
  logic       sense_5;
  logic [1:0] coins;
  logic       jam;
`ifdef COIN_VALIDATOR_TALLY_EN
  logic [7:0] tally_10;
  logic [7:0] tally_5;
`endif

  coin_validator #(
    .DEBOUNCE_CYCLES(D),
    .GAP_CYCLES     (G),
    .JAM_CYCLES     (J)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .sense_10(sense_10),
    .sense_5 (sense_5),
    .coins   (coins),
    .jam     (jam)
`ifdef COIN_VALIDATOR_TALLY_EN
    ,
    .tally_10(tally_10),
    .tally_5 (tally_5)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Reference model: each channel holds a debounced level, the length of the
  // current run of samples disagreeing with it, and a count of high samples
  // while the level is high. Index 0 is ten cents, 1 is five cents.
  int m_s1[2], m_s2[2], m_lvl[2], m_run[2], m_hcnt[2], m_flag[2], m_pend[2];
  int m_tally[2];
  int m_gap, m_coins, m_jam;

  task automatic model_edge(input bit rst, input bit r10, input bit r5);
    int acc[2];
    int x;
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        m_s1[c] = 0; m_s2[c] = 0; m_lvl[c] = 0; m_run[c] = 0;
        m_hcnt[c] = 0; m_flag[c] = 0; m_pend[c] = 0; m_tally[c] = 0;
      end
      m_gap = 0; m_coins = 0; m_jam = 0;
      return;
    end
    m_jam = (m_flag[0] != 0 || m_flag[1] != 0) ? 1 : 0;
    for (int c = 0; c < 2; c++) begin
      x = m_s2[c];
      acc[c] = 0;
      m_s2[c] = m_s1[c];
      m_s1[c] = (c == 0) ? int'(r10) : int'(r5);
      if (m_lvl[c] == 0) begin
        if (x != 0) begin
          m_run[c]++;
          if (m_run[c] == D) begin
            m_lvl[c] = 1; m_run[c] = 0; m_hcnt[c] = 0; acc[c] = 1;
          end
        end else begin
          m_run[c] = 0;
        end
      end else begin
        if (x != 0) begin
          if (m_run[c] != 0) begin
            m_run[c] = 0; m_hcnt[c] = 0;
          end else if (m_hcnt[c] == J) begin
            m_flag[c] = 1;
          end else begin
            m_hcnt[c]++;
          end
        end else begin
          m_run[c]++;
          if (m_run[c] == D) begin
            m_lvl[c] = 0; m_run[c] = 0; m_hcnt[c] = 0; m_flag[c] = 0;
          end
        end
      end
    end
    m_coins = 0;
    if (m_gap != 0) begin
      m_gap--;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (m_coins == 0 && m_pend[c] != 0) begin
          m_coins = c + 1;
          m_pend[c] = 0;
          m_gap = G;
          if (m_tally[c] < 255) m_tally[c]++;
        end
      end
    end
    for (int c = 0; c < 2; c++) if (acc[c] != 0) m_pend[c] = 1;
  endtask

  int tr_coins[$];
  int tr_jam[$];

  // One clock: drive inputs, let DUT and model take the edge, compare at negedge.
  task automatic step(input bit rst, input bit s10, input bit s5);
    reset = rst; sense_10 = s10; sense_5 = s5;
    @(posedge clk);
    model_edge(rst, s10, s5);
    @(negedge clk);
    check("coins", int'(coins), m_coins);
    check("jam", int'(jam), m_jam);
`ifdef COIN_VALIDATOR_TALLY_EN
    check("tally_10", int'(tally_10), m_tally[0]);
    check("tally_5", int'(tally_5), m_tally[1]);
`endif
    tr_coins.push_back(int'(coins));
    tr_jam.push_back(int'(jam));
  endtask

  task automatic start_scenario();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    tr_coins.delete();
    tr_jam.delete();
  endtask

  function automatic int count_code(input int code);
    int n = 0;
    foreach (tr_coins[i]) if (tr_coins[i] == code) n++;
    return n;
  endfunction

  function automatic int first_idx(input int code);
    foreach (tr_coins[i]) if (tr_coins[i] == code) return i;
    return -1;
  endfunction

  bit lvl[2];
  int rem[2];
  int found;
  int random_coins;

  initial begin
    reset = 1'b1; sense_10 = 1'b0; sense_5 = 1'b0;

    // Reset state
    start_scenario();
    check("reset_coins", int'(coins), 0);
    check("reset_jam", int'(jam), 0);

    // Clean 10-cent coin
    start_scenario();
    for (int i = 0; i < 40; i++) step(1'b0, i < 20, 1'b0);
    check("clean_first_idx", first_idx(1), 6);
    check("clean_pulses", count_code(1), 1);
    check("clean_other", count_code(2) + count_code(3), 0);
    check("clean_jam", tr_jam.sum(), 0);

    // Glitch rejection on the 5-cent chute
    start_scenario();
    for (int i = 0; i < 40; i++) step(1'b0, 1'b0, (i < 3) || (i >= 4 && i < 7));
    check("glitch_no_coin", 40 - count_code(0), 0);

    // Simultaneous arrival
    start_scenario();
    for (int i = 0; i < 50; i++) step(1'b0, i < 20, i < 20);
    check("simul_10_idx", first_idx(1), 6);
    check("simul_5_idx", first_idx(2), 9);
    check("simul_10_once", count_code(1), 1);
    check("simul_5_once", count_code(2), 1);
    check("simul_never_11", count_code(3), 0);

    // Jam on the 5-cent chute
    start_scenario();
    for (int i = 0; i < 140; i++) step(1'b0, 1'b0, i < 100);
    check("jam_coin_idx", first_idx(2), 6);
    check("jam_one_coin", 140 - count_code(0), 1);
    check("jam_low_69", tr_jam[69], 0);
    check("jam_high_71", tr_jam[71], 1);
    check("jam_high_105", tr_jam[105], 1);
    check("jam_low_106", tr_jam[106], 0);

    // Reset in the cycle the first coin appears
    start_scenario();
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      step(1'b0, 1'b1, 1'b1);
      if (coins == 2'b01) found = 1;
    end
    check("midflight_coin_seen", found, 1);
    step(1'b1, 1'b0, 1'b0);
    check("midflight_reset_coins", int'(coins), 0);
    check("midflight_reset_jam", int'(jam), 0);
`ifdef COIN_VALIDATOR_TALLY_EN
    check("midflight_reset_tally", int'(tally_10) + int'(tally_5), 0);
`endif
    tr_coins.delete();
    for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 1'b0);
    check("midflight_no_coin", 30 - count_code(0), 0);

    // Randomised traffic with occasional long holds and rare resets
    start_scenario();
    lvl[0] = 1'b0; lvl[1] = 1'b0; rem[0] = 0; rem[1] = 0;
    for (int i = 0; i < 2500; i++) begin
      for (int c = 0; c < 2; c++) begin
        if (rem[c] == 0) begin
          lvl[c] = ~lvl[c];
          case ($urandom_range(0, 9))
            0:       rem[c] = int'($urandom_range(60, 90));
            1, 2, 3: rem[c] = int'($urandom_range(1, 3));
            default: rem[c] = int'($urandom_range(4, 12));
          endcase
        end
      end
      step($urandom_range(0, 399) == 0, lvl[0], lvl[1]);
      rem[0]--; rem[1]--;
    end
    random_coins = count_code(1) + count_code(2);
    check("random_saw_coins", (random_coins > 0) ? 1 : 0, 1);
    check("random_never_11", count_code(3), 0);

`ifdef COIN_VALIDATOR_TALLY_EN
    // Tally saturation: 300 clean ten-cent coins
    start_scenario();
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < 16; i++) step(1'b0, i < 8, 1'b0);
    end
    check("tally_10_sat", int'(tally_10), 255);
    check("tally_5_zero", int'(tally_5), 0);
    check("tally_coin_count", count_code(1), 300);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
